// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port valid/ready memory.
// One transaction in flight at a time, with a watchdog that aborts a stuck memory handshake.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  a_valid_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    input  logic                  a_wr_rd_i,
    output logic                  a_ready_o,
    output logic                  a_done_o,
    output logic                  a_err_o,
    output logic [DATA_WIDTH-1:0] a_rdata_o,

    input  logic                  b_valid_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    input  logic                  b_wr_rd_i,
    output logic                  b_ready_o,
    output logic                  b_done_o,
    output logic                  b_err_o,
    output logic [DATA_WIDTH-1:0] b_rdata_o,

    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i
);

    // state | meaning
    // IDLE  | no transaction in flight, arbitrating between A and B
    // BUSY  | valid_o held to memory, waiting for ready_i or watchdog expiry
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state;
    state_t        state_nx;
    logic          last_gnt;   // 0 = A, 1 = B
    logic          owner;      // 0 = A, 1 = B
    logic [CW-1:0] cnt;
    logic          sel_a;
    logic          sel_b;
    logic          accept;
    logic          xfer_ok;
    logic          xfer_to;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        sel_a    = a_valid_i && (!b_valid_i || last_gnt);
        sel_b    = b_valid_i && (!a_valid_i || !last_gnt);
        state_nx = state;
        accept   = 1'b0;
        xfer_ok  = 1'b0;
        xfer_to  = 1'b0;
        case (state)
            IDLE: begin
                if (sel_a || sel_b) begin
                    accept   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // ready_i in the last allowed cycle still counts as success
                if (ready_i) begin
                    xfer_ok  = 1'b1;
                    state_nx = IDLE;
                end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
                    xfer_to  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Gated by rst_i so no requester sees an accept that reset would discard
    assign a_ready_o = rst_i && (state == IDLE) && sel_a;
    assign b_ready_o = rst_i && (state == IDLE) && sel_b;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_o   <= 1'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            wr_rd_o   <= 1'b0;
            a_done_o  <= 1'b0;
            a_err_o   <= 1'b0;
            a_rdata_o <= '0;
            b_done_o  <= 1'b0;
            b_err_o   <= 1'b0;
            b_rdata_o <= '0;
            cnt       <= '0;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
        end else begin
            a_done_o <= 1'b0;
            a_err_o  <= 1'b0;
            b_done_o <= 1'b0;
            b_err_o  <= 1'b0;
            if (accept) begin
                addr_o   <= sel_a ? a_addr_i  : b_addr_i;
                wdata_o  <= sel_a ? a_wdata_i : b_wdata_i;
                wr_rd_o  <= sel_a ? a_wr_rd_i : b_wr_rd_i;
                valid_o  <= 1'b1;
                owner    <= sel_b;
                last_gnt <= sel_b;
                cnt      <= '0;
            end else if (xfer_ok || xfer_to) begin
                valid_o <= 1'b0;
                cnt     <= '0;
                if (!owner) begin
                    a_done_o <= 1'b1;
                    a_err_o  <= xfer_to;
                    if (xfer_ok && !wr_rd_o) begin
                        a_rdata_o <= rdata_i;
                    end
                end else begin
                    b_done_o <= 1'b1;
                    b_err_o  <= xfer_to;
                    if (xfer_ok && !wr_rd_o) begin
                        b_rdata_o <= rdata_i;
                    end
                end
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, write, wait-state read,
// round-robin fairness, watchdog timeout and reset in the middle of a transaction.
module tb_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          a_valid_i, b_valid_i;
    logic [AW-1:0] a_addr_i, b_addr_i;
    logic [DW-1:0] a_wdata_i, b_wdata_i;
    logic          a_wr_rd_i, b_wr_rd_i;
    logic          a_ready_o, a_done_o, a_err_o;
    logic          b_ready_o, b_done_o, b_err_o;
    logic [DW-1:0] a_rdata_o, b_rdata_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          wr_rd_o, valid_o;
    logic          ready_i;
    logic [DW-1:0] rdata_i;

    int nchecks = 0;
    int nerrors = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_wr_rd_i(a_wr_rd_i),
        .a_ready_o(a_ready_o), .a_done_o(a_done_o), .a_err_o(a_err_o), .a_rdata_o(a_rdata_o),
        .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i), .b_wr_rd_i(b_wr_rd_i),
        .b_ready_o(b_ready_o), .b_done_o(b_done_o), .b_err_o(b_err_o), .b_rdata_o(b_rdata_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .wr_rd_o(wr_rd_o), .valid_o(valid_o),
        .ready_i(ready_i), .rdata_i(rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    int ngr;
    int nda;
    int ndb;
    int vcnt;
    logic last_owner;
    logic order [4];

    initial begin
        rst_i     = 1'b0;
        a_valid_i = 1'($urandom_range(1));
        b_valid_i = 1'($urandom_range(1));
        a_addr_i  = AW'($urandom);
        b_addr_i  = AW'($urandom);
        a_wdata_i = DW'($urandom);
        b_wdata_i = DW'($urandom);
        a_wr_rd_i = 1'($urandom_range(1));
        b_wr_rd_i = 1'($urandom_range(1));
        ready_i   = 1'($urandom_range(1));
        rdata_i   = DW'($urandom);

        // reset with random inputs
        tick();
        tick();
        check("rst_valid", valid_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_wr_rd", wr_rd_o, 0);
        check("rst_a_ready", a_ready_o, 0);
        check("rst_b_ready", b_ready_o, 0);
        check("rst_a_done_err", {a_done_o, a_err_o}, 0);
        check("rst_b_done_err", {b_done_o, b_err_o}, 0);
        check("rst_a_rdata", a_rdata_o, 0);
        check("rst_b_rdata", b_rdata_o, 0);

        rst_i     = 1'b1;
        b_valid_i = 1'b0;
        a_valid_i = 1'b1;
        a_addr_i  = 4'd3;
        a_wdata_i = 16'hBEEF;
        a_wr_rd_i = 1'b1;
        ready_i   = 1'b1;
        #1;
        check("rel_a_ready", a_ready_o, 1);
        check("rel_b_ready", b_ready_o, 0);

        // single write, ready tied high
        tick();
        a_valid_i = 1'b0;
        a_addr_i  = 4'd9;
        a_wdata_i = 16'h0000;
        check("wr_valid", valid_o, 1);
        check("wr_addr", addr_o, 3);
        check("wr_wdata", wdata_o, 16'hBEEF);
        check("wr_wr_rd", wr_rd_o, 1);
        check("wr_busy_ready", {a_ready_o, b_ready_o}, 0);
        tick();
        check("wr_a_done", a_done_o, 1);
        check("wr_a_err", a_err_o, 0);
        check("wr_valid_low", valid_o, 0);
        check("wr_b_done", b_done_o, 0);
        check("wr_a_rdata_kept", a_rdata_o, 0);

        // B read with three wait states
        ready_i   = 1'b0;
        rdata_i   = 16'h1234;
        b_valid_i = 1'b1;
        b_addr_i  = 4'd5;
        b_wr_rd_i = 1'b0;
        #1;
        check("rd_b_ready", b_ready_o, 1);
        tick();
        b_valid_i = 1'b0;
        b_addr_i  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ready_i = 1'b1;
            check("rd_valid", valid_o, 1);
            check("rd_addr", addr_o, 5);
            check("rd_wr_rd", wr_rd_o, 0);
            check("rd_no_done", {a_done_o, b_done_o}, 0);
            tick();
        end
        check("rd_b_done", b_done_o, 1);
        check("rd_b_err", b_err_o, 0);
        check("rd_b_rdata", b_rdata_o, 16'h1234);
        check("rd_a_done", a_done_o, 0);
        check("rd_valid_low", valid_o, 0);

        // fairness: both requesting from reset release
        rst_i = 1'b0;
        tick();
        rst_i     = 1'b1;
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        a_wr_rd_i = 1'b0;
        b_wr_rd_i = 1'b0;
        ready_i   = 1'b1;
        rdata_i   = 16'h5A5A;
        #1;
        ngr = 0;
        nda = 0;
        ndb = 0;
        last_owner = 1'b0;
        for (int i = 0; i < 20 && ngr < 4; i++) begin
            check("arb_onehot", {31'd0, a_ready_o && b_ready_o}, 0);
            if (a_done_o) begin
                nda++;
                check("arb_a_done_owner", last_owner, 0);
            end
            if (b_done_o) begin
                ndb++;
                check("arb_b_done_owner", last_owner, 1);
            end
            if (a_ready_o) begin
                order[ngr] = 1'b0;
                ngr++;
                last_owner = 1'b0;
            end else if (b_ready_o) begin
                order[ngr] = 1'b1;
                ngr++;
                last_owner = 1'b1;
            end
            tick();
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();
        if (a_done_o) nda++;
        if (b_done_o) ndb++;
        check("arb_grants", ngr, 4);
        check("arb_order0", order[0], 0);
        check("arb_order1", order[1], 1);
        check("arb_order2", order[2], 0);
        check("arb_order3", order[3], 1);
        check("arb_a_dones", nda, 2);
        check("arb_b_dones", ndb, 2);

        // watchdog: A read with ready stuck low
        ready_i   = 1'b0;
        rdata_i   = 16'hDEAD;
        a_valid_i = 1'b1;
        a_wr_rd_i = 1'b0;
        a_addr_i  = 4'd7;
        tick();
        a_valid_i = 1'b0;
        b_valid_i = 1'b1;
        b_wr_rd_i = 1'b0;
        b_addr_i  = 4'd2;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!valid_o) break;
            vcnt++;
            check("to_b_wait", b_ready_o, 0);
            check("to_no_done", a_done_o, 0);
            tick();
        end
        check("to_valid_cycles", vcnt, 8);
        check("to_a_done", a_done_o, 1);
        check("to_a_err", a_err_o, 1);
        check("to_a_rdata_kept", a_rdata_o, 16'h5A5A);
        check("to_b_ready_in_done", b_ready_o, 1);
        tick();
        b_valid_i = 1'b0;
        ready_i   = 1'b1;
        check("to_b_valid", valid_o, 1);
        check("to_b_addr", addr_o, 2);
        tick();
        check("to_b_done", b_done_o, 1);
        check("to_b_err", b_err_o, 0);
        check("to_b_rdata", b_rdata_o, 16'hDEAD);

        // reset during BUSY abandons the transaction
        ready_i   = 1'b0;
        a_valid_i = 1'b1;
        a_wr_rd_i = 1'b1;
        tick();
        a_valid_i = 1'b0;
        tick();
        check("mr_busy", valid_o, 1);
        rst_i = 1'b0;
        tick();
        check("mr_valid_low", valid_o, 0);
        check("mr_no_done", a_done_o, 0);
        rst_i     = 1'b1;
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        #1;
        check("mr_tie_a", a_ready_o, 1);
        check("mr_tie_b", b_ready_o, 0);
        check("mr_still_no_done", a_done_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
